// File: rtl/decode_imm_stage.sv
// Decode-stage skid buffer feeding sign_extender: 2-entry FIFO with per-head immediate decode,
// flush, and a wrapping retired-instruction counter.
module decode_imm_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_opcode,
    output logic [23:0]      out_imm24,
    output logic             out_signop,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e           state_q, state_d;
    logic [31:0]      buf_q [DEPTH];
    logic [31:0]      buf_d [DEPTH];
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             push, pop;
    logic [31:0]      head;
    logic [5:0]       op;
    logic             unused_head;

    assign in_ready    = (state_q != StFull);
    assign out_valid   = (state_q != StEmpty);
    assign push        = in_valid & in_ready & ~flush;
    assign pop         = out_valid & out_ready & ~flush;
    assign retired_cnt = retired_q;

    // buf[0] is always the head; buf[1] only holds data in StFull.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        retired_d = retired_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d  = StOne;
                        buf_d[0] = in_instr;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        buf_d[0] = in_instr;
                    end else if (push) begin
                        state_d  = StFull;
                        buf_d[1] = in_instr;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_d  = StOne;
                        buf_d[0] = buf_q[1];
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        if (pop) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Payload needs no reset: it is only observed while state says it is valid.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign head        = buf_q[0];
    assign op          = head[31:26];
    assign unused_head = ^head[25:24];

    always_comb begin
        out_opcode = '0;
        out_imm24  = '0;
        out_signop = 1'b0;
        if (out_valid) begin
            out_opcode = op;
            unique case (op[5:4])
                2'b11: begin
                    out_imm24  = head[23:0];
                    out_signop = 1'b1;
                end
                2'b01: begin
                    // Odd I-class opcodes zero-extend the 16-bit field.
                    out_signop = ~op[0];
                    out_imm24  = {{8{head[15] & ~op[0]}}, head[15:0]};
                end
                default: begin
                    out_imm24  = '0;
                    out_signop = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_imm_stage.sv
// Bench for decode_imm_stage: directed scenarios plus random traffic checked against a
// queue-based reference model.
module tb_decode_imm_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [23:0] out_imm24;
    logic        out_signop;
    logic [15:0] retired_cnt;

    decode_imm_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_imm24   (out_imm24),
        .out_signop  (out_signop),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] q [$];
    int unsigned cnt_model = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Decode rules restated arithmetically from the field definitions.
    function automatic void ref_decode(input logic [31:0] w, output int unsigned op,
                                       output int unsigned imm, output int unsigned s);
        int unsigned cls, low;
        op  = w >> 26;
        cls = op / 16;
        low = w % 65536;
        imm = 0;
        s   = 0;
        if (cls == 3) begin
            imm = w % (1 << 24);
            s   = 1;
        end else if (cls == 1) begin
            s   = (op % 2 == 0) ? 1 : 0;
            imm = (s == 1 && low >= 32768) ? low + 32'hFF0000 : low;
        end
    endfunction

    task automatic check_model();
        int unsigned op, imm, s;
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) ref_decode(q[0], op, imm, s);
        else begin op = 0; imm = 0; s = 0; end
        check("opcode", out_opcode, op);
        check("imm24", out_imm24, imm);
        check("signop", out_signop, s);
        check("retired", retired_cnt, cnt_model % 65536);
    endtask

    // One clock: drive, advance model, sample at the following negedge.
    task automatic cycle(input logic rst, input logic f, input logic v, input logic [31:0] w,
                         input logic r, input logic do_check);
        logic push, pop;
        rst_n     = ~rst;
        flush     = f;
        in_valid  = v;
        in_instr  = w;
        out_ready = r;
        push = v && (q.size() < 2) && !f;
        pop  = (q.size() > 0) && r && !f;
        if (rst) begin
            q.delete();
            cnt_model = 0;
        end else if (f) begin
            q.delete();
        end else begin
            if (pop) begin
                void'(q.pop_front());
                cnt_model++;
            end
            if (push) q.push_back(w);
        end
        @(posedge clk);
        @(negedge clk);
        if (do_check) check_model();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;

        // Reset, then a J-class push held under backpressure.
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        cycle(0, 0, 1, 32'hC0FF2609, 0, 1);
        check("j_valid", out_valid, 1);
        check("j_imm", out_imm24, 24'hFF2609);
        check("j_signop", out_signop, 1);
        check("j_opcode", out_opcode, 6'h30);

        // I-class sign handling.
        cycle(1, 0, 0, 0, 0, 1);
        cycle(0, 0, 1, 32'h4000_8001, 1, 1);
        check("i_even_imm", out_imm24, 24'hFF8001);
        check("i_even_s", out_signop, 1);
        cycle(0, 0, 1, 32'h4400_8001, 1, 1);
        check("i_odd_imm", out_imm24, 24'h008001);
        check("i_odd_s", out_signop, 0);
        cycle(0, 0, 0, 0, 1, 1);
        check("i_retired", retired_cnt, 2);

        // Backpressure: A, B fill; C is held off until a slot frees.
        cycle(1, 0, 0, 0, 0, 1);
        cycle(0, 0, 1, 32'h0000_000A, 0, 1);
        cycle(0, 0, 1, 32'h3400_000B, 0, 1);
        check("bp_full", in_ready, 0);
        cycle(0, 0, 1, 32'hC000_000C, 0, 1);
        check("bp_head_a", out_opcode, 6'h00);
        cycle(0, 0, 1, 32'hC000_000C, 1, 1);
        check("bp_head_b", out_opcode, 6'h0D);
        check("bp_ready_back", in_ready, 1);
        cycle(0, 0, 1, 32'hC000_000C, 1, 1);
        check("bp_head_c", out_imm24, 24'h00000C);
        cycle(0, 0, 0, 0, 1, 1);
        check("bp_retired", retired_cnt, 3);

        // Streaming push+pop in ONE.
        cycle(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, $urandom, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        check("stream_retired", retired_cnt, 8);

        // Flush from FULL with same-cycle push and pop.
        cycle(0, 0, 1, $urandom, 0, 1);
        cycle(0, 0, 1, $urandom, 0, 1);
        cycle(0, 1, 1, $urandom, 1, 1);
        check("flush_valid", out_valid, 0);
        check("flush_ready", in_ready, 1);
        check("flush_cnt", retired_cnt, 8);

        // Random traffic including occasional flush and mid-run reset.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 64) == 0, ($urandom % 16) == 0, $urandom % 4 != 0, $urandom,
                  $urandom % 3 != 0, 1);
        end

        // Counter wrap: 65536 pops from a fresh counter.
        cycle(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 65537; i++) cycle(0, 0, 1, $urandom, 1, (i % 1024) == 0);
        check_model();
        check("wrap_zero", retired_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_imm_stage.md
# decode_imm_stage

Decode-stage buffer between instruction fetch and `sign_extender`. Accepts 32-bit instructions over a valid/ready handshake and holds them in a 2-entry skid buffer. For the head entry it extracts the 24-bit immediate field and the `signop` control, which feed `sign_extender` `in` and `signop` directly. Supports pipeline flush and counts retired instructions.

## Interface
- `DEPTH`, 2, buffer entries; fixed at 2, no other value supported.
- `CNT_W`, 16, width of retired-instruction counter.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `flush` input 1: discard all buffered entries.
- `in_valid` input 1: fetch presents an instruction.
- `in_instr` input 32: instruction word.
- `in_ready` output 1: stage can accept an instruction this cycle.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: downstream consumes head.
- `out_opcode` output 6: head `instr[31:26]`.
- `out_imm24` output 24: to `sign_extender.in`.
- `out_signop` output 1: to `sign_extender.signop`.
- `retired_cnt` output CNT_W: count of out handshakes.

## Operation
- Occupancy FSM with states EMPTY (0 entries), ONE, FULL (2 entries). Entries are stored FIFO-ordered: head = oldest.
- `push = in_valid & in_ready & ~flush`; `pop = out_valid & out_ready & ~flush`.
- Transitions:
  - EMPTY: push -> ONE.
  - ONE: push & ~pop -> FULL; pop & ~push -> EMPTY; push & pop -> ONE, with the new word as head.
  - FULL: pop -> ONE, second entry becomes head. No push in FULL.
- `in_ready` = (state != FULL). It is a combinational decode of the registered state only; no combinational path from `out_ready`.
- `out_valid` = (state != EMPTY).
- Field decode, combinational from the head word (op = `instr[31:26]`):
  - J-class, `op[5:4]==2'b11`: `out_imm24 = instr[23:0]`, `out_signop = 1`.
  - I-class, `op[5:4]==2'b01`: `out_signop = ~op[0]`. `out_imm24 = {{8{instr[15] & out_signop}}, instr[15:0]}`, so odd opcodes zero-extend the 16-bit field.
  - R-class, `op[5:4]` = 00 or 10: `out_imm24 = 0`, `out_signop = 0`.
- When EMPTY, `out_opcode`, `out_imm24` and `out_signop` are driven to 0.
- `retired_cnt` increments by 1 on each pop and wraps modulo 2^CNT_W with no saturation. `flush` does not change it.
- `flush`: next state EMPTY. It overrides any same-cycle push and pop; neither is counted nor stored.

## Timing
- Reset (`rst_n==0` at a clock edge): state EMPTY, `retired_cnt=0`. Resulting outputs: `in_ready=1`, `out_valid=0`, `out_opcode=0`, `out_imm24=0`, `out_signop=0`.
- Reset mid-operation discards buffered entries exactly like `flush`, and additionally clears the counter.
- Latency: an instruction accepted at edge N is visible at the outputs with `out_valid=1` immediately after edge N, i.e. usable in cycle N+1.
- Throughput: 1 instruction/cycle sustained when `out_ready` is held high.
- The head entry and its decoded outputs are stable while `out_valid & ~out_ready`.
- Downstream stall: after 2 accepts `in_ready` drops. It returns to 1 the cycle after the first pop.
- Upstream must hold `in_instr` stable while `in_valid & ~in_ready`.

## Test plan
- **Reset and single push:** Hold `rst_n=0` for 2 cycles -> all outputs at reset values. Then push `0xC0FF2609` (J-class, op=0x30) with `out_ready=0` -> next cycle `out_valid=1`, `out_imm24=0xFF2609`, `out_signop=1`, `out_opcode=0x30`.
- **I-class sign handling:** Push `0x4000_8001` (op=0x10), then `0x4400_8001` (op=0x11), with `out_ready=1` -> first head `imm24=0xFF8001`, `signop=1`; second head `imm24=0x008001`, `signop=0`; `retired_cnt` reaches 2.
- **Backpressure:** `out_ready=0`, push A then B -> `in_ready=0` after B. Further `in_valid` with word C is ignored. Raise `out_ready` -> A pops, then B, then C is accepted; order is A, B, C.
- **Simultaneous push/pop in ONE:** Stream 8 words with `in_valid=out_ready=1` -> state stays ONE, each word pops in order one cycle after acceptance, `retired_cnt=8`.
- **Flush:** FULL with a same-cycle `in_valid=1` and `out_ready=1`, assert `flush` -> next cycle `out_valid=0`, `in_ready=1`, `retired_cnt` unchanged.
- **Counter wrap:** Preload by streaming 65536 pops (or force `CNT_W=4` and do 16 pops) -> `retired_cnt` returns to 0.
